// File: rtl/bakraid_bank_server.sv
// bakraid_bank_server: serves loader writes and four round-robin ROM banks onto a single-command memory backend.
// Latency: BA_ACK 2 cycles after the request, each read word 1 cycle after MEM_DV; backpressure: MEM_REQ held until MEM_GNT.
module bakraid_bank_server #(
    parameter int BURST = 2,
    parameter int AW    = 22
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          DOWNLOADING,
    input  logic [AW-1:0] PROG_ADDR,
    input  logic [15:0]   PROG_DATA,
    input  logic [1:0]    PROG_MASK,
    input  logic [1:0]    PROG_BA,
    input  logic          PROG_WE,
    output logic          PROG_RDY,
    input  logic [AW-1:0] BA0_ADDR,
    input  logic [AW-1:0] BA1_ADDR,
    input  logic [AW-1:0] BA2_ADDR,
    input  logic [AW-1:0] BA3_ADDR,
    input  logic [3:0]    BA_RD,
    input  logic          BA_WR,
    input  logic [15:0]   BA0_DIN,
    input  logic [1:0]    BA0_DIN_M,
    output logic [3:0]    BA_ACK,
    output logic [3:0]    BA_DST,
    output logic [3:0]    BA_RDY,
    output logic [3:0]    BA_DOK,
    output logic [15:0]   DATA_READ,
    output logic          MEM_REQ,
    output logic          MEM_WE,
    output logic [1:0]    MEM_BA,
    output logic [AW-1:0] MEM_ADDR,
    output logic [15:0]   MEM_DIN,
    output logic [1:0]    MEM_MASK,
    input  logic          MEM_GNT,
    input  logic          MEM_DV,
    input  logic [15:0]   MEM_DOUT
);
    typedef enum logic [1:0] {IDLE, CMD, RDATA} state_t;
    localparam logic [1:0] LAST_WORD = 2'(BURST - 1);

    state_t        state;
    logic [1:0]    rr;
    logic [1:0]    cnt;
    logic          is_prog;
    logic          prog_guard;
    logic [3:0]    cand;
    logic [3:0]    bank_oh;
    logic [1:0]    pick;
    logic [1:0]    idx;
    logic          pick_vld;
    logic [AW-1:0] pick_addr;

    assign bank_oh = 4'b0001 << MEM_BA;

    // First candidate at or after rr, wrapping 3 -> 0.
    always_comb begin
        cand     = BA_RD | {3'b000, BA_WR};
        pick     = 2'd0;
        pick_vld = 1'b0;
        idx      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = rr + i[1:0];
            if (!pick_vld && cand[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        case (pick)
            2'd0:    pick_addr = BA0_ADDR;
            2'd1:    pick_addr = BA1_ADDR;
            2'd2:    pick_addr = BA2_ADDR;
            default: pick_addr = BA3_ADDR;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            rr         <= 2'd0;
            cnt        <= 2'd0;
            is_prog    <= 1'b0;
            prog_guard <= 1'b0;
            PROG_RDY   <= 1'b0;
            BA_ACK     <= 4'd0;
            BA_DST     <= 4'd0;
            BA_RDY     <= 4'd0;
            BA_DOK     <= 4'd0;
            DATA_READ  <= 16'd0;
            MEM_REQ    <= 1'b0;
            MEM_WE     <= 1'b0;
            MEM_BA     <= 2'd0;
            MEM_ADDR   <= '0;
            MEM_DIN    <= 16'd0;
            MEM_MASK   <= 2'd0;
        end else begin
            BA_ACK     <= 4'd0;
            BA_DST     <= 4'd0;
            BA_RDY     <= 4'd0;
            BA_DOK     <= 4'd0;
            PROG_RDY   <= 1'b0;
            prog_guard <= 1'b0;
            case (state)
                IDLE: begin
                    if (DOWNLOADING) begin
                        // The loader keeps PROG_WE high for one cycle after PROG_RDY.
                        if (PROG_WE && !prog_guard) begin
                            MEM_REQ  <= 1'b1;
                            MEM_WE   <= 1'b1;
                            MEM_BA   <= PROG_BA;
                            MEM_ADDR <= PROG_ADDR;
                            MEM_DIN  <= PROG_DATA;
                            MEM_MASK <= PROG_MASK;
                            is_prog  <= 1'b1;
                            state    <= CMD;
                        end
                    end else if (pick_vld) begin
                        MEM_REQ  <= 1'b1;
                        MEM_BA   <= pick;
                        MEM_ADDR <= pick_addr;
                        is_prog  <= 1'b0;
                        rr       <= pick + 2'd1;
                        if (pick == 2'd0 && BA_WR) begin
                            MEM_WE   <= 1'b1;
                            MEM_DIN  <= BA0_DIN;
                            MEM_MASK <= BA0_DIN_M;
                        end else begin
                            MEM_WE <= 1'b0;
                        end
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (MEM_GNT) begin
                        MEM_REQ <= 1'b0;
                        if (is_prog) begin
                            PROG_RDY   <= 1'b1;
                            prog_guard <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            BA_ACK <= bank_oh;
                            if (MEM_WE) begin
                                BA_RDY <= bank_oh;
                                state  <= IDLE;
                            end else begin
                                state <= RDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (MEM_DV) begin
                        DATA_READ <= MEM_DOUT;
                        BA_RDY    <= bank_oh;
                        BA_DOK    <= bank_oh;
                        if (cnt == 2'd0) BA_DST <= bank_oh;
                        if (cnt == LAST_WORD) begin
                            cnt   <= 2'd0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end else if (cnt != 2'd0) begin
                        BA_DOK <= bank_oh;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bakraid_bank_server.sv
// Directed bench for bakraid_bank_server (BURST=2, AW=22).
module tb_bakraid_bank_server;
    localparam int AW = 22;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b1;
    logic          DOWNLOADING = 1'b0;
    logic [AW-1:0] PROG_ADDR = '0;
    logic [15:0]   PROG_DATA = 16'd0;
    logic [1:0]    PROG_MASK = 2'd0;
    logic [1:0]    PROG_BA = 2'd0;
    logic          PROG_WE = 1'b0;
    logic          PROG_RDY;
    logic [AW-1:0] BA0_ADDR = 22'h000AA0;
    logic [AW-1:0] BA1_ADDR = 22'h000BB1;
    logic [AW-1:0] BA2_ADDR = 22'h012345;
    logic [AW-1:0] BA3_ADDR = 22'h03CCC3;
    logic [3:0]    BA_RD = 4'h0;
    logic          BA_WR = 1'b0;
    logic [15:0]   BA0_DIN = 16'd0;
    logic [1:0]    BA0_DIN_M = 2'd0;
    logic [3:0]    BA_ACK, BA_DST, BA_RDY, BA_DOK;
    logic [15:0]   DATA_READ;
    logic          MEM_REQ, MEM_WE;
    logic [1:0]    MEM_BA;
    logic [AW-1:0] MEM_ADDR;
    logic [15:0]   MEM_DIN;
    logic [1:0]    MEM_MASK;
    logic          MEM_GNT = 1'b0;
    logic          MEM_DV = 1'b0;
    logic [15:0]   MEM_DOUT = 16'd0;

    int tests = 0;
    int failed = 0;

    bakraid_bank_server #(.BURST(2), .AW(AW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DOWNLOADING(DOWNLOADING),
        .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA), .PROG_MASK(PROG_MASK),
        .PROG_BA(PROG_BA), .PROG_WE(PROG_WE), .PROG_RDY(PROG_RDY),
        .BA0_ADDR(BA0_ADDR), .BA1_ADDR(BA1_ADDR), .BA2_ADDR(BA2_ADDR), .BA3_ADDR(BA3_ADDR),
        .BA_RD(BA_RD), .BA_WR(BA_WR), .BA0_DIN(BA0_DIN), .BA0_DIN_M(BA0_DIN_M),
        .BA_ACK(BA_ACK), .BA_DST(BA_DST), .BA_RDY(BA_RDY), .BA_DOK(BA_DOK),
        .DATA_READ(DATA_READ), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_BA(MEM_BA),
        .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_MASK(MEM_MASK),
        .MEM_GNT(MEM_GNT), .MEM_DV(MEM_DV), .MEM_DOUT(MEM_DOUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input logic [1:0] b);
        case (b)
            2'd0:    return 22'h000AA0;
            2'd1:    return 22'h000BB1;
            2'd2:    return 22'h012345;
            default: return 22'h03CCC3;
        endcase
    endfunction

    // Serve one bank read: optional grant stall, two words back to back.
    task automatic serve_read(input string tag, input logic [1:0] b, input logic [15:0] w0,
                              input logic [15:0] w1, input int stall);
        int n;
        logic stable;
        logic [3:0] oh;
        oh = 4'b0001 << b;
        n = 0;
        while (!MEM_REQ && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_req"}, 32'(MEM_REQ), 32'd1);
        chk({tag, "_ba"}, 32'(MEM_BA), 32'(b));
        chk({tag, "_addr"}, 32'(MEM_ADDR), 32'(exp_addr(b)));
        chk({tag, "_we"}, 32'(MEM_WE), 32'd0);
        if (stall > 0) begin
            stable = 1'b1;
            for (int k = 0; k < stall; k++) begin
                step();
                if (MEM_REQ !== 1'b1 || MEM_ADDR !== exp_addr(b) || MEM_BA !== b || MEM_WE !== 1'b0)
                    stable = 1'b0;
                if (BA_ACK !== 4'd0) stable = 1'b0;
            end
            chk({tag, "_stall_stable"}, 32'(stable), 32'd1);
        end
        MEM_GNT = 1'b1;
        step();
        MEM_GNT = 1'b0;
        chk({tag, "_ack"}, 32'(BA_ACK), 32'(oh));
        chk({tag, "_req_low"}, 32'(MEM_REQ), 32'd0);
        chk({tag, "_no_rdy_at_ack"}, 32'(BA_RDY), 32'd0);
        BA_RD[b] = 1'b0;
        MEM_DV = 1'b1;
        MEM_DOUT = w0;
        step();
        chk({tag, "_w0_rdy"}, 32'(BA_RDY), 32'(oh));
        chk({tag, "_w0_dst"}, 32'(BA_DST), 32'(oh));
        chk({tag, "_w0_dok"}, 32'(BA_DOK), 32'(oh));
        chk({tag, "_w0_data"}, 32'(DATA_READ), 32'(w0));
        MEM_DOUT = w1;
        step();
        MEM_DV = 1'b0;
        chk({tag, "_w1_rdy"}, 32'(BA_RDY), 32'(oh));
        chk({tag, "_w1_dst"}, 32'(BA_DST), 32'd0);
        chk({tag, "_w1_dok"}, 32'(BA_DOK), 32'(oh));
        chk({tag, "_w1_data"}, 32'(DATA_READ), 32'(w1));
        step();
        chk({tag, "_end_dok"}, 32'(BA_DOK), 32'd0);
        chk({tag, "_end_rdy"}, 32'(BA_RDY), 32'd0);
    endtask

    initial begin
        logic any_req;
        logic any_ack;
        logic any_strobe;

        // Reset with every bank requesting.
        #2;
        RESET_N = 1'b0;
        BA_RD = 4'hF;
        step();
        step();
        step();
        chk("rst_strobes", 32'({BA_ACK, BA_RDY, BA_DST, BA_DOK}), 32'd0);
        chk("rst_mem", 32'({MEM_REQ, MEM_WE, MEM_BA, MEM_MASK, PROG_RDY, MEM_DIN}), 32'd0);
        chk("rst_addr", 32'(MEM_ADDR), 32'd0);
        chk("rst_data", 32'(DATA_READ), 32'd0);
        RESET_N = 1'b1;
        step();
        chk("rst_first_req", 32'(MEM_REQ), 32'd1);
        chk("rst_first_addr", 32'(MEM_ADDR), 32'(22'h000AA0));

        // Round-robin: 0,1,2,3 then again after re-raising all four.
        serve_read("rr_a0", 2'd0, 16'h1000, 16'h1001, 0);
        serve_read("rr_a1", 2'd1, 16'h1110, 16'h1111, 0);
        serve_read("rr_a2", 2'd2, 16'h1220, 16'h1221, 0);
        serve_read("rr_a3", 2'd3, 16'h1330, 16'h1331, 0);
        BA_RD = 4'hF;
        serve_read("rr_b0", 2'd0, 16'h2000, 16'h2001, 0);
        serve_read("rr_b1", 2'd1, 16'h2110, 16'h2111, 0);
        serve_read("rr_b2", 2'd2, 16'h2220, 16'h2221, 0);
        serve_read("rr_b3", 2'd3, 16'h2330, 16'h2331, 0);

        // Single bank-2 read with exact request timing.
        step();
        chk("single_idle", 32'(MEM_REQ), 32'd0);
        BA_RD = 4'h4;
        step();
        chk("single_req_k1", 32'(MEM_REQ), 32'd1);
        serve_read("single", 2'd2, 16'hA5A5, 16'h5A5A, 0);

        // Grant stalled for 20 cycles.
        BA_RD = 4'h2;
        serve_read("stall", 2'd1, 16'h7E01, 16'h7E02, 20);

        // Stray MEM_DV while idle.
        MEM_DV = 1'b1;
        MEM_DOUT = 16'hFFFF;
        any_strobe = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if ((BA_RDY | BA_DST | BA_DOK | BA_ACK) !== 4'd0 || MEM_REQ !== 1'b0) any_strobe = 1'b1;
        end
        MEM_DV = 1'b0;
        chk("stray_dv_strobes", 32'(any_strobe), 32'd0);
        chk("stray_dv_data_hold", 32'(DATA_READ), 32'h7E02);

        // Reset in the middle of a read burst; bank 3 keeps requesting.
        BA_RD = 4'h8;
        step();
        chk("mid_req", 32'(MEM_REQ), 32'd1);
        MEM_GNT = 1'b1;
        step();
        MEM_GNT = 1'b0;
        chk("mid_ack", 32'(BA_ACK), 32'h8);
        MEM_DV = 1'b1;
        MEM_DOUT = 16'h1234;
        step();
        MEM_DV = 1'b0;
        chk("mid_w0_rdy", 32'(BA_RDY), 32'h8);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_strobes", 32'({BA_ACK, BA_RDY, BA_DST, BA_DOK}), 32'd0);
        chk("mid_rst_data", 32'(DATA_READ), 32'd0);
        chk("mid_rst_req", 32'(MEM_REQ), 32'd0);
        step();
        step();
        RESET_N = 1'b1;
        step();
        chk("mid_reserve_req", 32'(MEM_REQ), 32'd1);
        serve_read("mid_reserve", 2'd3, 16'h4321, 16'h8765, 0);

        // Loader write while bank 0 read is pending.
        DOWNLOADING = 1'b1;
        BA_RD = 4'h1;
        PROG_ADDR = 22'h000100;
        PROG_DATA = 16'h00C3;
        PROG_MASK = 2'b11;
        PROG_BA = 2'd3;
        PROG_WE = 1'b1;
        any_ack = 1'b0;
        step();
        chk("dl_req", 32'(MEM_REQ), 32'd1);
        chk("dl_we", 32'(MEM_WE), 32'd1);
        chk("dl_ba", 32'(MEM_BA), 32'd3);
        chk("dl_addr", 32'(MEM_ADDR), 32'h100);
        chk("dl_din", 32'(MEM_DIN), 32'h00C3);
        chk("dl_mask", 32'(MEM_MASK), 32'd3);
        MEM_GNT = 1'b1;
        step();
        MEM_GNT = 1'b0;
        chk("dl_prog_rdy", 32'(PROG_RDY), 32'd1);
        chk("dl_req_low", 32'(MEM_REQ), 32'd0);
        if (BA_ACK !== 4'd0) any_ack = 1'b1;
        step();
        PROG_WE = 1'b0;
        chk("dl_prog_rdy_pulse", 32'(PROG_RDY), 32'd0);
        any_req = MEM_REQ;
        for (int k = 0; k < 5; k++) begin
            step();
            if (MEM_REQ !== 1'b0) any_req = 1'b1;
            if (BA_ACK !== 4'd0 || PROG_RDY !== 1'b0) any_ack = 1'b1;
        end
        chk("dl_single_write", 32'(any_req), 32'd0);
        chk("dl_no_ack", 32'(any_ack), 32'd0);

        // Bank-0 write beats the pending bank-0 read.
        DOWNLOADING = 1'b0;
        BA_WR = 1'b1;
        BA0_DIN = 16'hBEEF;
        BA0_DIN_M = 2'b01;
        step();
        chk("wr_req", 32'(MEM_REQ), 32'd1);
        chk("wr_we", 32'(MEM_WE), 32'd1);
        chk("wr_ba", 32'(MEM_BA), 32'd0);
        chk("wr_addr", 32'(MEM_ADDR), 32'h000AA0);
        chk("wr_din", 32'(MEM_DIN), 32'hBEEF);
        chk("wr_mask", 32'(MEM_MASK), 32'd1);
        MEM_GNT = 1'b1;
        step();
        MEM_GNT = 1'b0;
        BA_WR = 1'b0;
        chk("wr_ack", 32'(BA_ACK), 32'h1);
        chk("wr_rdy", 32'(BA_RDY), 32'h1);
        chk("wr_no_dst", 32'(BA_DST), 32'd0);
        chk("wr_req_low", 32'(MEM_REQ), 32'd0);
        step();
        chk("wr_rdy_pulse", 32'(BA_RDY), 32'd0);
        serve_read("wr_then_rd", 2'd0, 16'hCAFE, 16'hF00D, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
